// File: rtl/cbfp1_seq_ctrl_if.sv
// Bundle between the CBFP1 sequencer and its surroundings: butterfly-side strobes in,
// datapath/buffer controls out. The master is the upstream driver, the slave is the sequencer.
interface cbfp1_seq_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned BLK_WIDTH  = 3
);
    logic                  alert_cbfp;
    logic                  din_valid;
    logic                  mag_en;
    logic                  min_clr;
    logic                  min_en;
    logic                  min_latch;
    logic                  wr_en;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  rd_en;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  shift_en;
    logic                  valid_mod1;
    logic [BLK_WIDTH-1:0]  blk_idx;
    logic                  frame_done;
    logic                  overrun_err;

    modport master (
        output alert_cbfp, din_valid,
        input  mag_en, min_clr, min_en, min_latch, wr_en, wr_bank, wr_addr,
               rd_en, rd_bank, rd_addr, shift_en, valid_mod1, blk_idx, frame_done, overrun_err
    );

    modport slave (
        input  alert_cbfp, din_valid,
        output mag_en, min_clr, min_en, min_latch, wr_en, wr_bank, wr_addr,
               rd_en, rd_bank, rd_addr, shift_en, valid_mod1, blk_idx, frame_done, overrun_err
    );
endinterface

// File: rtl/cbfp1_seq_ctrl.sv
// CBFP1 stage sequencer: counts beats into blocks, times mag/min detection and the block
// minimum latch, and schedules ping-pong buffer read bursts feeding the bit-shift stage.
module cbfp1_seq_ctrl #(
    parameter int unsigned BEATS_PER_BLOCK = 8,
    parameter int unsigned ADDR_WIDTH      = 3,
    parameter int unsigned NUM_BLOCKS      = 8,
    parameter int unsigned BLK_WIDTH       = 3,
    parameter int unsigned MAG_LAT         = 1,
    parameter int unsigned MIN_LAT         = 1
) (
    input  logic              clk,
    input  logic              rst,
    cbfp1_seq_ctrl_if.slave   bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BEATS_PER_BLOCK - 1);
    localparam logic [BLK_WIDTH-1:0]  LAST_BLK  = BLK_WIDTH'(NUM_BLOCKS - 1);

    typedef enum logic {IDLE, FILL} wr_state_e;
    wr_state_e state_q, state_d;

    logic                  accept, blk_last, frame_last, flush;
    logic [ADDR_WIDTH-1:0] base_addr, wr_addr_q, wr_addr_d;
    logic [BLK_WIDTH-1:0]  base_blk, wr_blk_q, wr_blk_d;
    logic                  base_bank, wr_bank_q, wr_bank_d;

    // mag-detect delay line: valid, first/last beat of block, bank, block index
    logic [MAG_LAT-1:0]                mv_q, mv_d, mf_q, mf_d, ml_q, ml_d, mb_q, mb_d;
    logic [MAG_LAT-1:0][BLK_WIDTH-1:0] mk_q, mk_d;
    // min-detect delay line carrying the block-end token to min_latch
    logic [MIN_LAT-1:0]                lv_q, lv_d, lb_q, lb_d;
    logic [MIN_LAT-1:0][BLK_WIDTH-1:0] lk_q, lk_d;

    logic                  latch, lat_bank;
    logic [BLK_WIDTH-1:0]  lat_blk;
    logic                  burst_end, rd_free, rd_start;
    logic                  rd_en_q, rd_en_d, rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [BLK_WIDTH-1:0]  rd_blk_q, rd_blk_d, pend_blk_q, pend_blk_d;
    logic                  pending_q, pending_d, pend_bank_q, pend_bank_d;
    logic                  overrun_q, overrun_d;
    logic                  sh_en_q, sh_en_d, sh_fd_q, sh_fd_d;
    logic [BLK_WIDTH-1:0]  sh_blk_q, sh_blk_d, vblk_q, vblk_d;
    logic                  vld_q, vld_d, fd_q, fd_d;

    // alert always flushes: when nothing is in flight this equals a plain frame start
    always_comb begin
        flush      = bus.alert_cbfp;
        base_addr  = flush ? '0 : wr_addr_q;
        base_blk   = flush ? '0 : wr_blk_q;
        base_bank  = flush ? 1'b0 : wr_bank_q;
        accept     = bus.din_valid && (flush || state_q == FILL);
        blk_last   = accept && (base_addr == LAST_ADDR);
        frame_last = blk_last && (base_blk == LAST_BLK);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (flush && !frame_last) state_d = FILL;
            FILL: if (frame_last) state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mag_en  = accept;
        bus.wr_en   = accept;
        bus.wr_addr = accept ? base_addr : '0;
        bus.wr_bank = accept && base_bank;
    end

    always_comb begin
        wr_addr_d = base_addr;
        wr_blk_d  = base_blk;
        wr_bank_d = base_bank;
        if (accept) begin
            wr_addr_d = blk_last ? '0 : base_addr + 1'b1;
            if (blk_last) begin
                wr_bank_d = ~base_bank;
                wr_blk_d  = (base_blk == LAST_BLK) ? '0 : base_blk + 1'b1;
            end
        end
    end

    always_comb begin
        mv_d = '0; mf_d = '0; ml_d = '0; mb_d = '0; mk_d = '0;
        lv_d = '0; lb_d = '0; lk_d = '0;
        if (!flush) begin
            for (int unsigned i = 1; i < MAG_LAT; i++) begin
                mv_d[i] = mv_q[i-1]; mf_d[i] = mf_q[i-1]; ml_d[i] = ml_q[i-1];
                mb_d[i] = mb_q[i-1]; mk_d[i] = mk_q[i-1];
            end
            for (int unsigned i = 1; i < MIN_LAT; i++) begin
                lv_d[i] = lv_q[i-1]; lb_d[i] = lb_q[i-1]; lk_d[i] = lk_q[i-1];
            end
            lv_d[0] = mv_q[MAG_LAT-1] && ml_q[MAG_LAT-1];
            lb_d[0] = mb_q[MAG_LAT-1];
            lk_d[0] = mk_q[MAG_LAT-1];
        end
        mv_d[0] = accept;
        mf_d[0] = accept && (base_addr == '0);
        ml_d[0] = blk_last;
        mb_d[0] = base_bank;
        mk_d[0] = base_blk;
    end

    assign latch    = lv_q[MIN_LAT-1];
    assign lat_bank = lb_q[MIN_LAT-1];
    assign lat_blk  = lk_q[MIN_LAT-1];

    // a latch on the last cycle of a burst chains straight into the next burst
    always_comb begin
        burst_end = rd_en_q && (rd_addr_q == LAST_ADDR);
        rd_free   = !rd_en_q || burst_end;
        rd_start  = rd_free && (pending_q || latch);

        rd_en_d   = rd_en_q && !burst_end;
        rd_addr_d = rd_en_d ? rd_addr_q + 1'b1 : '0;
        rd_bank_d = rd_en_d && rd_bank_q;
        rd_blk_d  = rd_en_d ? rd_blk_q : '0;
        if (rd_start) begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            rd_bank_d = pending_q ? pend_bank_q : lat_bank;
            rd_blk_d  = pending_q ? pend_blk_q : lat_blk;
        end

        pending_d   = pending_q && !rd_start;
        pend_bank_d = pend_bank_q;
        pend_blk_d  = pend_blk_q;
        overrun_d   = overrun_q;
        if (latch && !(rd_start && !pending_q)) begin
            pending_d   = 1'b1;
            pend_bank_d = lat_bank;
            pend_blk_d  = lat_blk;
            if (pending_q && !rd_start) overrun_d = 1'b1;
        end

        sh_en_d  = rd_en_q;
        sh_blk_d = rd_blk_q;
        sh_fd_d  = burst_end && (rd_blk_q == LAST_BLK);
        vld_d    = sh_en_q;
        vblk_d   = sh_blk_q;
        fd_d     = sh_fd_q;

        if (flush) begin
            rd_en_d = 1'b0; rd_addr_d = '0; rd_bank_d = 1'b0; rd_blk_d = '0;
            pending_d = 1'b0; pend_bank_d = 1'b0; pend_blk_d = '0;
            overrun_d = overrun_q;
            sh_en_d = 1'b0; sh_blk_d = '0; sh_fd_d = 1'b0;
            vld_d = 1'b0; vblk_d = '0; fd_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0; wr_blk_q <= '0; wr_bank_q <= 1'b0;
            mv_q <= '0; mf_q <= '0; ml_q <= '0; mb_q <= '0; mk_q <= '0;
            lv_q <= '0; lb_q <= '0; lk_q <= '0;
            rd_en_q <= 1'b0; rd_addr_q <= '0; rd_bank_q <= 1'b0; rd_blk_q <= '0;
            pending_q <= 1'b0; pend_bank_q <= 1'b0; pend_blk_q <= '0; overrun_q <= 1'b0;
            sh_en_q <= 1'b0; sh_blk_q <= '0; sh_fd_q <= 1'b0;
            vld_q <= 1'b0; vblk_q <= '0; fd_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d; wr_blk_q <= wr_blk_d; wr_bank_q <= wr_bank_d;
            mv_q <= mv_d; mf_q <= mf_d; ml_q <= ml_d; mb_q <= mb_d; mk_q <= mk_d;
            lv_q <= lv_d; lb_q <= lb_d; lk_q <= lk_d;
            rd_en_q <= rd_en_d; rd_addr_q <= rd_addr_d; rd_bank_q <= rd_bank_d; rd_blk_q <= rd_blk_d;
            pending_q <= pending_d; pend_bank_q <= pend_bank_d; pend_blk_q <= pend_blk_d;
            overrun_q <= overrun_d;
            sh_en_q <= sh_en_d; sh_blk_q <= sh_blk_d; sh_fd_q <= sh_fd_d;
            vld_q <= vld_d; vblk_q <= vblk_d; fd_q <= fd_d;
        end
    end

    assign bus.min_en      = mv_q[MAG_LAT-1];
    assign bus.min_clr     = mv_q[MAG_LAT-1] && mf_q[MAG_LAT-1];
    assign bus.min_latch   = latch;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.shift_en    = sh_en_q;
    assign bus.valid_mod1  = vld_q;
    assign bus.blk_idx     = vblk_q;
    assign bus.frame_done  = fd_q;
    assign bus.overrun_err = overrun_q;
endmodule
